write_back: RTL

- Final pipeline stage. Directly downstream of the execute stage; consumes its registered outputs.
- Commits results to the register file (value plus flags), issues data-memory stores, and reports retirement.
- Stalls execute through in_hold while a store is waiting for memory acknowledgement.

---
 rtl/write_back.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/write_back.sv
// write_back: final pipeline stage -- commits register/flag results, issues data-memory stores
// and reports retirement. Define STORE_TIMEOUT_EN to abort stores that are never acknowledged.
module write_back #(
   parameter int REG_INDEX_WIDTH = 5,
   parameter int STORE_TIMEOUT   = 255
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic [31:0]                in_pc,
   input  logic [REG_INDEX_WIDTH-1:0] in_destination_register,
   input  logic                       in_is_writing_memory,
   input  logic [3:0]                 in_flags,
   input  logic [31:0]                in_destination_value,
   input  logic [31:0]                in_adjustment_value,
   input  logic                       in_has_flushed,
   output logic                       in_hold,
   output logic [REG_INDEX_WIDTH-1:0] reg_read_index,
   input  logic [31:0]                reg_read_value,
   output logic                       rf_write_enable,
   output logic [REG_INDEX_WIDTH-1:0] rf_write_index,
   output logic [31:0]                rf_write_value,
   output logic                       flags_write_enable,
   output logic [3:0]                 flags_value,
   output logic                       mem_write_request,
   output logic [31:0]                mem_address,
   output logic [31:0]                mem_data,
   input  logic                       mem_ack,
   output logic                       retire_valid,
   output logic [31:0]                retire_pc,
   output logic [31:0]                retired_count,
   output logic                       has_flushed,
   output logic                       store_error
);

   typedef enum logic {
      IDLE       = 1'b0,
      STORE_WAIT = 1'b1
   } state_t;

   state_t      state_reg;
   logic [31:0] store_pc_reg;
   logic        accept;
   logic        accept_store;
   logic        accept_other;
   logic        store_done;
   logic        timeout_hit;
   logic [31:0] retire_step;

   if (STORE_TIMEOUT < 1) begin : g_timeout_check
      $error("write_back: STORE_TIMEOUT must be at least 1");
   end

`ifdef STORE_TIMEOUT_EN
   logic [31:0] wait_count_reg;
   assign timeout_hit = (state_reg == STORE_WAIT) && !mem_ack
                        && (wait_count_reg == 32'(STORE_TIMEOUT));
`else
   assign timeout_hit = 1'b0;
   assign store_error = 1'b0;
`endif

   assign reg_read_index = in_destination_register;
   assign in_hold        = reset_n && (state_reg == STORE_WAIT) && !mem_ack;
   assign accept         = in_valid && !in_hold;
   assign accept_store   = accept && in_is_writing_memory;
   assign accept_other   = accept && !in_is_writing_memory;
   assign store_done     = (state_reg == STORE_WAIT) && (mem_ack || timeout_hit);

   // An ack edge can retire the pending store and a newly accepted non-store together.
   assign retire_step = {31'd0, store_done} + {31'd0, accept_other};

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg          <= IDLE;
         store_pc_reg       <= '0;
         rf_write_enable    <= 1'b0;
         rf_write_index     <= '0;
         rf_write_value     <= '0;
         flags_write_enable <= 1'b0;
         flags_value        <= '0;
         mem_write_request  <= 1'b0;
         mem_address        <= '0;
         mem_data           <= '0;
         retire_valid       <= 1'b0;
         retire_pc          <= '0;
         retired_count      <= '0;
         has_flushed        <= 1'b0;
`ifdef STORE_TIMEOUT_EN
         wait_count_reg     <= '0;
         store_error        <= 1'b0;
`endif
      end else begin
         if (!in_hold) begin
            has_flushed <= in_has_flushed;
         end

         rf_write_enable    <= 1'b0;
         flags_write_enable <= 1'b0;
         retire_valid       <= 1'b0;
         retired_count      <= retired_count + retire_step;

         // The finishing store owns the single retire port when both complete together.
         if (store_done) begin
            retire_valid <= 1'b1;
            retire_pc    <= store_pc_reg;
         end else if (accept_other) begin
            retire_valid <= 1'b1;
            retire_pc    <= in_pc;
         end

         if (accept_other) begin
            rf_write_enable    <= (in_destination_register != '0);
            rf_write_index     <= in_destination_register;
            rf_write_value     <= in_destination_value;
            flags_write_enable <= 1'b1;
            flags_value        <= in_flags;
         end

         case (state_reg)
            IDLE: begin
               if (accept_store) begin
                  mem_write_request <= 1'b1;
                  mem_address       <= reg_read_value + in_adjustment_value;
                  mem_data          <= in_destination_value;
                  store_pc_reg      <= in_pc;
                  state_reg         <= STORE_WAIT;
               end
            end
            STORE_WAIT: begin
               if (accept_store) begin
                  mem_write_request <= 1'b1;
                  mem_address       <= reg_read_value + in_adjustment_value;
                  mem_data          <= in_destination_value;
                  store_pc_reg      <= in_pc;
                  state_reg         <= STORE_WAIT;
               end else if (store_done) begin
                  mem_write_request <= 1'b0;
                  state_reg         <= IDLE;
               end
            end
            default: begin
               mem_write_request <= 1'b0;
               state_reg         <= IDLE;
            end
         endcase

`ifdef STORE_TIMEOUT_EN
         if (accept_store) begin
            wait_count_reg <= '0;
         end else if ((state_reg == STORE_WAIT) && !mem_ack) begin
            wait_count_reg <= wait_count_reg + 32'd1;
         end
         if (timeout_hit) begin
            store_error <= 1'b1;
         end
`endif
      end
   end

endmodule
